// File: rtl/ds2411_pkg.sv
// Shared constants for the DS2411 read arbiter: status codes, CRC polynomial,
// FSM encodings and a bit-reverse helper for the family byte.
package ds2411_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_NODEV   = 2'd1,
    ST_CRC     = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  localparam logic [7:0] CRC_POLY      = 8'h8C;
  localparam logic [7:0] FAMILY_DS2411 = 8'h01;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_CRC     = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;
  localparam logic [2:0] S_BACKOFF = 3'd6;
  localparam logic [2:0] S_RESPOND = 3'd7;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/ds_crc8_serial.sv
// Bit-serial Dallas/Maxim CRC-8 (x^8+x^5+x^4+1, reflected), one bit per enabled clock.
module ds_crc8_serial
  import ds2411_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb  = r_crc[0] ^ i_bit;
  assign o_crc = r_crc;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_crc <= 8'h00;
    end else if (i_en) begin
      r_crc <= (r_crc >> 1) ^ (w_fb ? CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/ds2411_read_arbiter.sv
// Round-robin arbiter sharing one DS2411 ROM reader between NREQ requesters,
// with reader handshake sequencing, CRC/family check, retries and timeout.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for any request; grants round-robin
// SETTLE    | bus mux settling after bus_sel change
// LAUNCH    | rd_go held high until the reader reports working
// RUN       | reader busy; waiting for working to fall with done/error
// CRC       | shifting captured ROM through the serial CRC, MSB first
// RECOVER   | after a timeout, waiting for the reader to go idle
// BACKOFF   | bus recovery delay before the next attempt
// RESPOND   | one cycle to drive ack/serial/status and advance the pointer
module ds2411_read_arbiter
  import ds2411_pkg::*;
#(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned TIMEOUT_CYC  = 2000000,
  parameter bit          CHECK_FAMILY = 1'b1,
  parameter logic [7:0]  FAMILY_CODE  = FAMILY_DS2411,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned BACKOFF_CYC  = 100000,
  localparam int unsigned SEL_W       = $clog2(NREQ)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  i_req,
  output logic [NREQ-1:0]  o_ack,
  output logic [63:0]      o_serial,
  output logic [1:0]       o_status,
  output logic [SEL_W-1:0] o_bus_sel,
  output logic             o_rd_go,
  input  logic             i_rd_working,
  input  logic             i_rd_done,
  input  logic             i_rd_error,
  input  logic [63:0]      i_rd_result,
  output logic             o_busy
);

  localparam logic [31:0]     TMR_SETTLE  = 32'(SETTLE_CYC - 1);
  localparam logic [31:0]     TMR_TIMEOUT = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0]     TMR_BACKOFF = 32'(BACKOFF_CYC - 1);
  localparam logic [31:0]     TMR_CRC     = 32'd64;
  localparam logic [2:0]      RETRY_MAX   = 3'(MAX_RETRY);
  localparam logic [NREQ-1:0] ACK_ONE     = NREQ'(1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NREQ - 1);

  logic [2:0]       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_bus_sel;
  logic [2:0]       r_retry;
  logic [31:0]      r_tmr;
  logic [63:0]      r_word;
  logic [63:0]      r_shift;
  status_e          r_status;
  logic [NREQ-1:0]  r_ack;
  logic [63:0]      r_serial;
  logic [1:0]       r_status_out;
  logic             r_busy;

  logic [SEL_W-1:0] w_grant_hi;
  logic [SEL_W-1:0] w_grant_lo;
  logic             w_hi_vld;
  logic [SEL_W-1:0] w_grant;
  logic             w_tmr_zero;
  logic             w_run_end;
  logic             w_timeout;
  logic             w_fail_nodev;
  logic             w_fail_crc;
  logic             w_fail_tmo;
  logic             w_fail;
  status_e          w_fail_code;
  logic             w_crc_en;
  logic             w_crc_clr;
  logic [7:0]       w_crc;
  logic             w_crc_ok;

  // Lowest requester at or after the pointer, else lowest overall (wrap).
  always_comb begin
    w_grant_hi = '0;
    w_grant_lo = '0;
    w_hi_vld   = 1'b0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        w_grant_lo = SEL_W'(k);
        if (SEL_W'(k) >= r_ptr) begin
          w_grant_hi = SEL_W'(k);
          w_hi_vld   = 1'b1;
        end
      end
    end
    w_grant = w_hi_vld ? w_grant_hi : w_grant_lo;
  end

  assign w_tmr_zero   = (r_tmr == 32'd0);
  assign w_run_end    = !i_rd_working && (i_rd_done || i_rd_error);
  assign w_timeout    = w_tmr_zero &&
                        (((r_state == S_LAUNCH) && !i_rd_working) ||
                         ((r_state == S_RUN) && !w_run_end));
  assign w_fail_nodev = (r_state == S_RUN) && w_run_end && !i_rd_done;
  assign w_fail_crc   = (r_state == S_CRC) && w_tmr_zero && !w_crc_ok;
  assign w_fail_tmo   = (r_state == S_RECOVER) && !i_rd_working;
  assign w_fail       = w_fail_nodev || w_fail_crc || w_fail_tmo;
  assign w_fail_code  = w_fail_nodev ? ST_NODEV : (w_fail_crc ? ST_CRC : ST_TIMEOUT);

  assign w_crc_clr = (r_state != S_CRC);
  assign w_crc_en  = (r_state == S_CRC) && !w_tmr_zero;
  assign w_crc_ok  = (w_crc == 8'h00) &&
                     (!CHECK_FAMILY || (rev8(r_word[63:56]) == FAMILY_CODE));

  ds_crc8_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_bit (r_shift[63]),
    .o_crc (w_crc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_bus_sel    <= '0;
      r_retry      <= '0;
      r_tmr        <= '0;
      r_word       <= '0;
      r_shift      <= '0;
      r_status     <= ST_OK;
      r_ack        <= '0;
      r_serial     <= '0;
      r_status_out <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_bus_sel <= w_grant;
            r_busy    <= 1'b1;
            r_retry   <= '0;
            r_tmr     <= TMR_SETTLE;
            r_state   <= S_SETTLE;
          end
        end
        S_SETTLE, S_BACKOFF: begin
          if (w_tmr_zero) begin
            r_tmr   <= TMR_TIMEOUT;
            r_state <= S_LAUNCH;
          end else begin
            r_tmr <= r_tmr - 32'd1;
          end
        end
        S_LAUNCH: begin
          if (!w_tmr_zero) r_tmr <= r_tmr - 32'd1;
          if (i_rd_working)   r_state <= S_RUN;
          else if (w_timeout) r_state <= S_RECOVER;
        end
        S_RUN: begin
          if (!w_tmr_zero) r_tmr <= r_tmr - 32'd1;
          if (w_run_end && i_rd_done) begin
            r_word  <= i_rd_result;
            r_shift <= i_rd_result;
            r_tmr   <= TMR_CRC;
            r_state <= S_CRC;
          end else if (w_timeout) begin
            r_state <= S_RECOVER;
          end
        end
        S_CRC: begin
          if (!w_tmr_zero) begin
            r_shift <= {r_shift[62:0], 1'b0};
            r_tmr   <= r_tmr - 32'd1;
          end else if (w_crc_ok) begin
            r_status <= ST_OK;
            r_state  <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_ack        <= ACK_ONE << r_bus_sel;
          r_serial     <= ((r_status == ST_OK) || (r_status == ST_CRC)) ? r_word : 64'd0;
          r_status_out <= r_status;
          r_busy       <= 1'b0;
          r_ptr        <= (r_bus_sel == SEL_LAST) ? '0 : r_bus_sel + SEL_W'(1);
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Every failure path funnels here so retry accounting lives in one place.
      if (w_fail) begin
        r_status <= w_fail_code;
        if (r_retry < RETRY_MAX) begin
          r_retry <= r_retry + 3'd1;
          r_tmr   <= TMR_BACKOFF;
          r_state <= S_BACKOFF;
        end else begin
          r_state <= S_RESPOND;
        end
      end
    end
  end

  assign o_ack     = r_ack;
  assign o_serial  = r_serial;
  assign o_status  = r_status_out;
  assign o_bus_sel = r_bus_sel;
  assign o_rd_go   = (r_state == S_LAUNCH);
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_ds2411_read_arbiter.sv
// Scoreboard bench for ds2411_read_arbiter with a behavioural DS2411 reader model.
module tb_ds2411_read_arbiter;
  import ds2411_pkg::*;

  localparam int K_OK     = 0;
  localparam int K_ERR    = 1;
  localparam int K_SILENT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  ack;
  logic [63:0] serial;
  logic [1:0]  status;
  logic [1:0]  bus_sel;
  logic        rd_go;
  logic        rd_working, rd_done, rd_error;
  logic [63:0] rd_result;
  logic        busy;

  ds2411_read_arbiter #(
    .NREQ(3), .MAX_RETRY(2), .TIMEOUT_CYC(1000), .CHECK_FAMILY(1'b1),
    .FAMILY_CODE(8'h01), .SETTLE_CYC(16), .BACKOFF_CYC(40)
  ) dut (
    .clk(clk), .reset(reset), .i_req(req), .o_ack(ack), .o_serial(serial),
    .o_status(status), .o_bus_sel(bus_sel), .o_rd_go(rd_go),
    .i_rd_working(rd_working), .i_rd_done(rd_done), .i_rd_error(rd_error),
    .i_rd_result(rd_result), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [1:0] status; logic [63:0] serial; } exp_t;
  typedef struct { int kind; logic [63:0] word; } att_t;

  exp_t        sb[$];
  att_t        plan[$];
  exp_t        mon_e;
  att_t        cur_att;
  int          checks = 0;
  int          errors = 0;
  int          launches = 0;
  int          ack_total = 0;
  bit          hold_req = 1'b0;
  logic [63:0] good_word;
  logic [63:0] an27_word;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic mix;
    mix = c[0] ^ b;
    c = c >> 1;
    if (mix) c = c ^ 8'h8C;
    return c;
  endfunction

  // Reception order: byte k bit j lands at word[63-8k-j].
  function automatic logic [63:0] pack_rom(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    logic [7:0]  bytes [8];
    logic [63:0] w;
    bytes = '{b0, b1, b2, b3, b4, b5, b6, b7};
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++) w[63-8*k-j] = bytes[k][j];
    return w;
  endfunction

  function automatic logic [63:0] make_rom(input logic [7:0] fam, input logic [47:0] body);
    logic [63:0] w;
    logic [7:0]  c;
    w = pack_rom(fam, body[7:0], body[15:8], body[23:16], body[31:24], body[39:32], body[47:40], 8'h00);
    c = 8'h00;
    for (int i = 63; i >= 8; i--) c = crc_step(c, w[i]);
    for (int i = 0; i < 8; i++) w[7-i] = c[i];
    return w;
  endfunction

  task automatic push_exp(input int idx, input logic [1:0] st, input logic [63:0] ser);
    exp_t e;
    e.idx = idx; e.status = st; e.serial = ser;
    sb.push_back(e);
  endtask

  task automatic push_att(input int kind, input logic [63:0] w, input int n);
    att_t a;
    a.kind = kind; a.word = w;
    for (int i = 0; i < n; i++) plan.push_back(a);
  endtask

  // Requester side and scoreboard pop.
  always @(negedge clk) begin
    if (!reset && ack !== 3'b000) begin
      ack_total++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack got %b expected none", ack);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (ack !== (3'b001 << mon_e.idx)) begin
          errors++; $display("FAIL ack got %b expected %b", ack, 3'b001 << mon_e.idx);
        end
        checks++;
        if (status !== mon_e.status) begin
          errors++; $display("FAIL status got %0d expected %0d", status, mon_e.status);
        end
        checks++;
        if (serial !== mon_e.serial) begin
          errors++; $display("FAIL serial got %h expected %h", serial, mon_e.serial);
        end
        checks++;
        if (bus_sel !== 2'(mon_e.idx)) begin
          errors++; $display("FAIL bus_sel got %0d expected %0d", bus_sel, mon_e.idx);
        end
      end
      if (hold_req && sb.size() == 0) req = 3'b000;
      else if (!hold_req) req = req & ~ack;
    end
  end

  // Reader model: working rises 3 clk after go, falls 20 clk after go drops.
  initial begin
    rd_working = 1'b0; rd_done = 1'b0; rd_error = 1'b0; rd_result = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_go === 1'b1) begin
        launches++;
        if (plan.size() != 0) cur_att = plan.pop_front();
        else begin cur_att.kind = K_OK; cur_att.word = good_word; end
        rd_done = 1'b0; rd_error = 1'b0;
        if (cur_att.kind != K_SILENT) begin
          repeat (3) @(posedge clk);
          #1 rd_working = 1'b1;
        end
        while (rd_go === 1'b1) begin @(posedge clk); #1; end
        if (cur_att.kind != K_SILENT) begin
          repeat (20) @(posedge clk);
          #1 rd_working = 1'b0;
          if (cur_att.kind == K_ERR) rd_error = 1'b1;
          else begin rd_done = 1'b1; rd_result = cur_att.word; end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired, pending expected %0d", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending %0d expected 0 after %0d cycles", name, sb.size(), n);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_launches(input string name, input int exp_n);
    checks++;
    if (launches !== exp_n) begin
      errors++; $display("FAIL %s_launches got %0d expected %0d", name, launches, exp_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 3'b000;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL rst_ack got %b expected 000", ack); end
    checks++; if (serial !== 64'd0) begin errors++; $display("FAIL rst_serial got %h expected 0", serial); end
    checks++; if (status !== 2'd0) begin errors++; $display("FAIL rst_status got %0d expected 0", status); end
    checks++; if (bus_sel !== 2'd0) begin errors++; $display("FAIL rst_bus_sel got %0d expected 0", bus_sel); end
    checks++; if (rd_go !== 1'b0) begin errors++; $display("FAIL rst_rd_go got %b expected 0", rd_go); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    launches = 0; plan.delete();
    hold_req = 1'b1;
    push_exp(0, ST_OK, good_word); push_exp(1, ST_OK, good_word);
    push_exp(2, ST_OK, good_word); push_exp(0, ST_OK, good_word);
    req = 3'b111;
    wait_drain("rr", 2000);
    hold_req = 1'b0;
    check_launches("rr", 4);
  endtask

  task automatic test_single_ok();
    launches = 0; plan.delete();
    push_att(K_OK, good_word, 1);
    push_exp(0, ST_OK, good_word);
    req = 3'b001;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b expected 1", busy); end
    wait_drain("single", 1000);
    check_launches("single", 1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b expected 0", busy); end
  endtask

  task automatic test_crc_retry();
    launches = 0; plan.delete();
    push_att(K_OK, 64'h1, 3);
    push_exp(0, ST_CRC, 64'h1);
    req = 3'b001;
    wait_drain("crc", 2000);
    check_launches("crc", 3);
  endtask

  task automatic test_family();
    launches = 0; plan.delete();
    push_att(K_OK, an27_word, 3);
    push_exp(1, ST_CRC, an27_word);
    req = 3'b010;
    wait_drain("family", 2000);
    check_launches("family", 3);
  endtask

  task automatic test_timeout();
    launches = 0; plan.delete();
    push_att(K_SILENT, 64'd0, 3);
    push_exp(2, ST_TIMEOUT, 64'd0);
    req = 3'b100;
    wait_drain("timeout", 5000);
    check_launches("timeout", 3);
    checks++; if (rd_go !== 1'b0) begin errors++; $display("FAIL timeout_rd_go got %b expected 0", rd_go); end
  endtask

  task automatic test_error_retry();
    launches = 0; plan.delete();
    push_att(K_ERR, 64'd0, 1);
    push_att(K_OK, good_word, 1);
    push_exp(0, ST_OK, good_word);
    req = 3'b001;
    wait_drain("err_retry", 2000);
    check_launches("err_retry", 2);
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    int base;
    launches = 0; plan.delete();
    push_att(K_OK, good_word, 1);
    req = 3'b001;
    while (rd_working !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (rd_working !== 1'b1) begin errors++; $display("FAIL midrun_start working got %b expected 1", rd_working); end
    repeat (4) @(negedge clk);
    reset = 1'b1; req = 3'b000;
    @(negedge clk);
    checks++; if (rd_go !== 1'b0) begin errors++; $display("FAIL midrun_rd_go got %b expected 0", rd_go); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_busy got %b expected 0", busy); end
    checks++; if (serial !== 64'd0) begin errors++; $display("FAIL midrun_serial got %h expected 0", serial); end
    @(negedge clk);
    reset = 1'b0;
    base = ack_total;
    repeat (40) @(negedge clk);
    checks++;
    if (ack_total !== base) begin errors++; $display("FAIL midrun_no_ack got %0d acks expected 0", ack_total - base); end
    launches = 0; plan.delete();
    push_exp(0, ST_OK, good_word); push_exp(1, ST_OK, good_word);
    req = 3'b011;
    wait_drain("post_reset", 2000);
    check_launches("post_reset", 2);
  endtask

  initial begin
    good_word = make_rom(8'h01, 48'h9ABC_5678_1234);
    an27_word = pack_rom(8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2);
    test_reset();
    test_round_robin();
    test_single_ok();
    test_crc_retry();
    test_family();
    test_timeout();
    test_error_retry();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
